ibuf_enable_sequencer: RTL and testbench

IBUF_ENABLE_SEQUENCER -- requirements
Module: ibuf_enable_sequencer

---
 rtl/ibuf_seq_pkg.sv | 18 +
 rtl/ibuf_rr_arbiter.sv | 35 +++
 rtl/ibuf_enable_sequencer.sv | 118 +++++++++++
 tb/tb_ibuf_enable_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/ibuf_seq_pkg.sv
// Shared types and parameter limits for the I_BUF enable sequencer.
// Sequencer FSM states, legal parameter ranges and the index-width helper.
package ibuf_seq_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } seq_state_t;

  localparam int NUM_BUF_MAX = 32;
  localparam int SETTLE_MAX  = 255;

  // A single-buffer build still carries a 1-bit index so port widths never collapse to zero.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ibuf_rr_arbiter.sv
// Combinational round-robin pick among pending buffers, searching from last_grant+1 with wrap.
// Zero latency; no flow control, the caller samples grant only when it can accept it.
module ibuf_rr_arbiter
  import ibuf_seq_pkg::*;
#(
  parameter int NUM_BUF = 8
) (
  input  logic [NUM_BUF-1:0]          pending,
  input  logic [idx_w(NUM_BUF)-1:0]   last_grant,
  output logic [NUM_BUF-1:0]          grant,
  output logic [idx_w(NUM_BUF)-1:0]   idx,
  output logic                        any
);

  localparam int IW = idx_w(NUM_BUF);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    // Offset NUM_BUF lands back on last_grant itself, so it is considered last.
    for (int i = 1; i <= NUM_BUF; i++) begin
      cand = (int'(last_grant) + i) % NUM_BUF;
      if (!any && pending[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/ibuf_enable_sequencer.sv
// Serialises I_BUF enables: one buffer settles at a time, VALID rises SETTLE_CYCLES after its EN.
// Grants one cycle after a request is seen; dropped requests clear EN/VALID at the next edge.
module ibuf_enable_sequencer
  import ibuf_seq_pkg::*;
#(
  parameter int NUM_BUF       = 8,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [NUM_BUF-1:0]          REQ,
  output logic [NUM_BUF-1:0]          EN,
  output logic [NUM_BUF-1:0]          VALID,
  output logic                        BUSY,
  output logic [idx_w(NUM_BUF)-1:0]   ACTIVE_IDX
);

  localparam int IW = idx_w(NUM_BUF);
  localparam logic [7:0]    SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0] LAST_RESET  = IW'(NUM_BUF - 1);

  if (NUM_BUF < 1 || NUM_BUF > NUM_BUF_MAX) begin : g_bad_num_buf
    $error("ibuf_enable_sequencer: NUM_BUF=%0d outside 1..%0d", NUM_BUF, NUM_BUF_MAX);
  end
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > SETTLE_MAX) begin : g_bad_settle
    $error("ibuf_enable_sequencer: SETTLE_CYCLES=%0d outside 1..%0d", SETTLE_CYCLES, SETTLE_MAX);
  end

  seq_state_t          state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [NUM_BUF-1:0]  sel_q, sel_d;
  logic [IW-1:0]       last_q, last_d;
  logic [IW-1:0]       idx_d;
  logic [NUM_BUF-1:0]  en_d, valid_d;
  logic                busy_d;

  logic [NUM_BUF-1:0]  pending;
  logic [NUM_BUF-1:0]  arb_grant;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;
  logic                sel_req;

  assign pending = REQ & ~EN;
  assign sel_req = |(REQ & sel_q);

  ibuf_rr_arbiter #(
    .NUM_BUF (NUM_BUF)
  ) u_arb (
    .pending    (pending),
    .last_grant (last_q),
    .grant      (arb_grant),
    .idx        (arb_idx),
    .any        (arb_any)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    idx_d   = ACTIVE_IDX;
    // Any channel whose request is gone loses EN and VALID regardless of state.
    en_d    = EN & REQ;
    valid_d = VALID & REQ;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          en_d    = en_d | arb_grant;
          sel_d   = arb_grant;
          idx_d   = arb_idx;
          last_d  = arb_idx;
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (!sel_req) begin
          state_d = IDLE;
          sel_d   = '0;
          idx_d   = '0;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          valid_d = valid_d | sel_q;
          state_d = IDLE;
          sel_d   = '0;
          idx_d   = '0;
        end
      end
    endcase

    busy_d = (state_d == SETTLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      sel_q      <= '0;
      last_q     <= LAST_RESET;
      EN         <= '0;
      VALID      <= '0;
      BUSY       <= 1'b0;
      ACTIVE_IDX <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      EN         <= en_d;
      VALID      <= valid_d;
      BUSY       <= busy_d;
      ACTIVE_IDX <= idx_d;
    end
  end

endmodule

// File: tb/tb_ibuf_enable_sequencer.sv
// Directed bench: a 4-buffer/3-cycle instance driven from a vector table plus corner sequences,
// and a 1-buffer/1-cycle instance for the degenerate configuration.
module tb_ibuf_enable_sequencer;

  logic       clk;
  logic       rst_n_a, rst_n_b;
  logic [3:0] req_a;
  logic [3:0] en_a, valid_a;
  logic       busy_a;
  logic [1:0] idx_a;
  logic [0:0] req_b, en_b, valid_b, idx_b;
  logic       busy_b;

  int checks = 0;
  int errors = 0;

  ibuf_enable_sequencer #(.NUM_BUF(4), .SETTLE_CYCLES(3)) dut_a (
    .CLK(clk), .RST_N(rst_n_a), .REQ(req_a),
    .EN(en_a), .VALID(valid_a), .BUSY(busy_a), .ACTIVE_IDX(idx_a)
  );

  ibuf_enable_sequencer #(.NUM_BUF(1), .SETTLE_CYCLES(1)) dut_b (
    .CLK(clk), .RST_N(rst_n_b), .REQ(req_b),
    .EN(en_b), .VALID(valid_b), .BUSY(busy_b), .ACTIVE_IDX(idx_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] en;
    logic [3:0] valid;
    logic       busy;
    logic [1:0] idx;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic [3:0] q, input logic [3:0] e,
                              input logic [3:0] v, input logic b, input logic [1:0] i);
    vec_t t;
    t.rst_n = r; t.req = q; t.en = e; t.valid = v; t.busy = b; t.idx = i;
    tbl.push_back(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string name, input logic [3:0] e, input logic [3:0] v,
                         input logic b, input logic [1:0] i);
    checks++;
    if ({en_a, valid_a, busy_a, idx_a} !== {e, v, b, i}) begin
      errors++;
      $display("FAIL %s: got EN=%b VALID=%b BUSY=%b IDX=%0d, want EN=%b VALID=%b BUSY=%b IDX=%0d",
               name, en_a, valid_a, busy_a, idx_a, e, v, b, i);
    end
  endtask

  task automatic step_a(input string name, input logic r, input logic [3:0] q,
                        input logic [3:0] e, input logic [3:0] v, input logic b,
                        input logic [1:0] i);
    rst_n_a = r;
    req_a   = q;
    tick();
    check_a(name, e, v, b, i);
  endtask

  task automatic step_b(input string name, input logic r, input logic q,
                        input logic e, input logic v, input logic b);
    rst_n_b  = r;
    req_b[0] = q;
    tick();
    checks++;
    if ({en_b, valid_b, busy_b, idx_b} !== {e, v, b, 1'b0}) begin
      errors++;
      $display("FAIL %s: got EN=%b VALID=%b BUSY=%b IDX=%0d, want EN=%b VALID=%b BUSY=%b IDX=0",
               name, en_b, valid_b, busy_b, idx_b, e, v, b);
    end
  endtask

  initial begin
    logic [3:0] en_m;
    logic [3:0] v_m;

    rst_n_a = 1'b0; req_a = 4'b0000;
    rst_n_b = 1'b0; req_b = 1'b0;

    // Single request on channel 0, hold, then drop.
    add(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(1, 4'b0001, 4'b0001, 4'b0000, 1, 0);
    add(1, 4'b0001, 4'b0001, 4'b0000, 1, 0);
    add(1, 4'b0001, 4'b0001, 4'b0000, 1, 0);
    add(1, 4'b0001, 4'b0001, 4'b0001, 0, 0);
    add(1, 4'b0001, 4'b0001, 4'b0001, 0, 0);
    add(1, 4'b0000, 4'b0000, 4'b0000, 0, 0);

    // All four at once: serialized 0,1,2,3 with one idle cycle between grants.
    add(0, 4'b1111, 4'b0000, 4'b0000, 0, 0);
    for (int ch = 0; ch < 4; ch++) begin
      en_m = 4'((2 << ch) - 1);
      v_m  = 4'((1 << ch) - 1);
      for (int k = 0; k < 3; k++) add(1, 4'b1111, en_m, v_m, 1, 2'(ch));
      add(1, 4'b1111, en_m, en_m, 0, 0);
    end
    add(1, 4'b1111, 4'b1111, 4'b1111, 0, 0);

    // Drop valid channel 0 while channel 1 settles; channel 1 timing unaffected.
    add(0, 4'b0011, 4'b0000, 4'b0000, 0, 0);
    add(1, 4'b0011, 4'b0001, 4'b0000, 1, 0);
    add(1, 4'b0011, 4'b0001, 4'b0000, 1, 0);
    add(1, 4'b0011, 4'b0001, 4'b0000, 1, 0);
    add(1, 4'b0011, 4'b0001, 4'b0001, 0, 0);
    add(1, 4'b0011, 4'b0011, 4'b0001, 1, 1);
    add(1, 4'b0010, 4'b0010, 4'b0000, 1, 1);
    add(1, 4'b0010, 4'b0010, 4'b0000, 1, 1);
    add(1, 4'b0010, 4'b0010, 4'b0010, 0, 0);

    for (int n = 0; n < tbl.size(); n++) begin
      rst_n_a = tbl[n].rst_n;
      req_a   = tbl[n].req;
      tick();
      checks++;
      if ({en_a, valid_a, busy_a, idx_a} !==
          {tbl[n].en, tbl[n].valid, tbl[n].busy, tbl[n].idx}) begin
        errors++;
        $display("FAIL vec%0d: got EN=%b VALID=%b BUSY=%b IDX=%0d, want EN=%b VALID=%b BUSY=%b IDX=%0d",
                 n, en_a, valid_a, busy_a, idx_a,
                 tbl[n].en, tbl[n].valid, tbl[n].busy, tbl[n].idx);
      end
    end

    // Abort: channel 2 drops right after its EN rises; channel 3 follows after one idle cycle.
    step_a("abort_rst",   0, 4'b1100, 4'b0000, 4'b0000, 0, 0);
    step_a("abort_grant", 1, 4'b1100, 4'b0100, 4'b0000, 1, 2);
    step_a("abort_drop",  1, 4'b1000, 4'b0000, 4'b0000, 0, 0);
    step_a("abort_next",  1, 4'b1000, 4'b1000, 4'b0000, 1, 3);
    step_a("abort_cnt1",  1, 4'b1000, 4'b1000, 4'b0000, 1, 3);
    step_a("abort_cnt0",  1, 4'b1000, 4'b1000, 4'b0000, 1, 3);
    step_a("abort_valid", 1, 4'b1000, 4'b1000, 4'b1000, 0, 0);

    // Reset mid-settle of channel 1; afterwards channel 1 wins again since priority restarts at 0.
    step_a("rms_rst",     0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    step_a("rms_grant",   1, 4'b0010, 4'b0010, 4'b0000, 1, 1);
    step_a("rms_reset",   0, 4'b0110, 4'b0000, 4'b0000, 0, 0);
    step_a("rms_regrant", 1, 4'b0110, 4'b0010, 4'b0000, 1, 1);
    step_a("rms_cnt1",    1, 4'b0110, 4'b0010, 4'b0000, 1, 1);
    step_a("rms_cnt0",    1, 4'b0110, 4'b0010, 4'b0000, 1, 1);
    step_a("rms_valid",   1, 4'b0110, 4'b0010, 4'b0010, 0, 0);
    step_a("rms_next",    1, 4'b0110, 4'b0110, 4'b0010, 1, 2);

    // Single buffer, one-cycle settle: REQ 1,1,0,1,1.
    step_b("b1_rst",   0, 1'b0, 1'b0, 1'b0, 1'b0);
    step_b("b1_grant", 1, 1'b1, 1'b1, 1'b0, 1'b1);
    step_b("b1_valid", 1, 1'b1, 1'b1, 1'b1, 1'b0);
    step_b("b1_drop",  1, 1'b0, 1'b0, 1'b0, 1'b0);
    step_b("b1_regr",  1, 1'b1, 1'b1, 1'b0, 1'b1);
    step_b("b1_reval", 1, 1'b1, 1'b1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
